smem_writer: RTL and testbench
==============================

# smem_writer

Write-side front end for `shared_memory`. Accepts one job (string bytes plus pattern bytes) on a ready/valid byte stream and buffers the whole job. It then replays the job as a single contiguous `write` burst on the `w_data`/`write`/`w_sel` port: all string bytes first, then all pattern bytes. Finally it waits for the memory's `valid` before accepting the next job. Buffering is mandatory because any idle cycle inside a burst makes `shared_memory` end the load and reset its indices.

## Interface
- `BYTE`, 8, data width
- `MAX_STRING`, 32, string buffer depth (bytes)
- `MAX_PATTERN`, 8, pattern buffer depth (bytes)
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `in_data`  in  BYTE  job byte
- `in_sel`  in  1  0 = string byte, 1 = pattern byte
- `in_last`  in  1  marks the final byte of the job
- `in_valid`  in  1  upstream byte valid
- `in_ready`  out  1  block accepts a byte this cycle
- `w_data`  out  BYTE  to `shared_memory.w_data`
- `write`  out  1  to `shared_memory.write`
- `w_sel`  out  1  to `shared_memory.w_sel`
- `mem_valid`  in  1  from `shared_memory.valid`
- `done`  out  1  one-cycle pulse when the job is loaded
- `err`  out  1  sticky job error; cleared on the first accepted byte of the next job

## Operation
- States: COLLECT, SEND_STR, SEND_PAT, WAIT_VALID.
- **COLLECT**
  - `in_ready`=1. A byte is accepted when `in_valid & in_ready`.
  - `in_sel`=0 writes `str_buf[s_cnt]` and increments `s_cnt`. `in_sel`=1 writes `pat_buf[p_cnt]` and increments `p_cnt`. `s_cnt` is 6 bits (0..32); `p_cnt` is 4 bits (0..8).
  - String and pattern bytes may arrive interleaved in any order. Order within each class is preserved.
  - Overflow: a byte whose class buffer is full is dropped, `err` is set, and the counters saturate.
  - Accepted `in_last`, including its own byte:
    - If `s_cnt`=0 or `p_cnt`=0 after that byte, set `err`, clear both counters, and stay in COLLECT (job discarded, no burst).
    - Otherwise go to SEND_STR with idx=0.
- **SEND_STR**
  - Outputs: `write`=1, `w_sel`=0, `w_data`=`str_buf[idx]`.
  - idx increments each cycle. After idx = `s_cnt`-1, go to SEND_PAT with idx=0.
- **SEND_PAT**
  - Outputs: `write`=1, `w_sel`=1, `w_data`=`pat_buf[idx]`.
  - After idx = `p_cnt`-1, go to WAIT_VALID.
- **WAIT_VALID**
  - Outputs: `write`=0.
  - When `mem_valid`=1: pulse `done`, clear the counters, and go to COLLECT.
- `in_ready`=0 in every state except COLLECT.
- `w_data`=0 and `w_sel`=0 whenever `write`=0.
- Buffer contents are not cleared between jobs. Only the counters define the payload.

## Timing
- All outputs are registered. Reset values: `in_ready`=0 during reset and 1 in the first cycle after it; `write`=0, `w_sel`=0, `w_data`=0, `done`=0, `err`=0; state COLLECT, counters 0.
- `in_last` accepted at edge T: the first burst beat is driven from T+1, and the burst lasts exactly `s_cnt`+`p_cnt` consecutive cycles.
- The `write` fall is followed by `mem_valid` one cycle later from `shared_memory`. `done` asserts the cycle after `mem_valid` is sampled high.
- Minimum job-to-job gap: `in_ready` returns to 1 the same cycle `done` pulses.
- No idle cycle between the last string beat and the first pattern beat; the burst is never broken.
- `mem_valid` high in any state other than WAIT_VALID is ignored.
- Reset mid-burst: `write` drops at the next edge. The job and `err` are discarded, and the state returns to COLLECT.
- Full buffers (32 string + 8 pattern): burst of 40 beats, no err.

## Test plan
- String "abc" (0x61,0x62,0x63) + pattern "ab", `in_last` on the final pattern byte -> 5-beat burst: `w_sel` 0,0,0,1,1; data 61,62,63,61,62. `shared_memory` shows `str_last_idx`=2, `pat_last_idx`=1, valid; `done` pulses once.
- Interleaved input P0,S0,P1,S1 with `in_last` on S1 -> burst order S0,S1,P0,P1, contiguous with no `write` gap.
- 33 string bytes + 1 pattern byte -> `err`=1; 33-beat burst (32 string + 1 pattern); the 33rd string byte is dropped.
- Job with 4 string bytes and no pattern byte (`in_last` on string byte 4) -> `err`=1, `write` never asserts, `in_ready` stays 1; the next valid job clears `err` and completes.
- Reset asserted on burst beat 3 of 10 -> `write`=0 at the next edge and all outputs at reset values; a following 2+1 job loads correctly.
- Two back-to-back jobs with `in_valid` held high -> `in_ready`=0 from `in_last` acceptance until `done`. The second burst starts only after the first `done`, and the buffers show the second job's data only.

Source files
------------

// File: rtl/smem_writer.sv
`default_nettype none
// ============================================================================
//  Module   : smem_writer
//  Purpose  : Write-side front end for shared_memory. Buffers one complete job
//             (string bytes plus pattern bytes, arriving interleaved on a
//             ready/valid byte stream), then replays it as a single unbroken
//             write burst: all string bytes, then all pattern bytes. It then
//             waits for the memory's valid before taking the next job.
//             shared_memory ends a load on any idle cycle inside a burst, so
//             the whole job must be resident before the first beat goes out.
//
//  Ports    : clk        in   clock
//             reset      in   synchronous, active-high reset
//             in_data    in   job byte
//             in_sel     in   0 = string byte, 1 = pattern byte
//             in_last    in   final byte of the job
//             in_valid   in   upstream byte valid
//             in_ready   out  byte accepted this cycle when in_valid is high
//             w_data     out  burst data to shared_memory.w_data
//             write      out  burst strobe to shared_memory.write
//             w_sel      out  burst class to shared_memory.w_sel
//             mem_valid  in   shared_memory.valid
//             done       out  one-cycle pulse when the job is loaded
//             err        out  sticky job error, cleared by the next job
//
//  Revision : 1.0  initial release
// ============================================================================
module smem_writer #(
   parameter int BYTE        = 8,
   parameter int MAX_STRING  = 32,
   parameter int MAX_PATTERN = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [BYTE-1:0] in_data,
   input  logic            in_sel,
   input  logic            in_last,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [BYTE-1:0] w_data,
   output logic            write,
   output logic            w_sel,
   input  logic            mem_valid,
   output logic            done,
   output logic            err
);

   // Counters hold 0..MAX inclusive; buffer indices only need 0..MAX-1.
   localparam int S_CNT_W = $clog2(MAX_STRING + 1);
   localparam int P_CNT_W = $clog2(MAX_PATTERN + 1);
   localparam int S_IDX_W = (MAX_STRING  > 1) ? $clog2(MAX_STRING)  : 1;
   localparam int P_IDX_W = (MAX_PATTERN > 1) ? $clog2(MAX_PATTERN) : 1;
   localparam int IDX_W   = (S_CNT_W > P_CNT_W) ? S_CNT_W : P_CNT_W;

   localparam logic [S_CNT_W-1:0] S_FULL  = S_CNT_W'(MAX_STRING);
   localparam logic [P_CNT_W-1:0] P_FULL  = P_CNT_W'(MAX_PATTERN);
   localparam logic [S_CNT_W-1:0] S_ONE   = S_CNT_W'(1);
   localparam logic [P_CNT_W-1:0] P_ONE   = P_CNT_W'(1);
   localparam logic [IDX_W-1:0]   IDX_ONE = IDX_W'(1);

   localparam logic [1:0] ST_COLLECT    = 2'd0;
   localparam logic [1:0] ST_SEND_STR   = 2'd1;
   localparam logic [1:0] ST_SEND_PAT   = 2'd2;
   localparam logic [1:0] ST_WAIT_VALID = 2'd3;

   // ------------------------------------------------------------------------
   // State and storage
   // ------------------------------------------------------------------------
   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic [S_CNT_W-1:0] r_s_cnt;
   logic [P_CNT_W-1:0] r_p_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic               r_err;
   logic [BYTE-1:0]    r_str_buf [MAX_STRING];
   logic [BYTE-1:0]    r_pat_buf [MAX_PATTERN];

   // Registered outputs
   logic               r_in_ready;
   logic               r_write;
   logic               r_w_sel;
   logic [BYTE-1:0]    r_w_data;
   logic               r_done;

   // Next values for the registered outputs and the burst index
   logic               w_nxt_ready;
   logic               w_nxt_write;
   logic               w_nxt_sel;
   logic [BYTE-1:0]    w_nxt_data;
   logic               w_nxt_done;
   logic [IDX_W-1:0]   w_nxt_idx;

   // ------------------------------------------------------------------------
   // Collect-side decode
   // ------------------------------------------------------------------------
   logic               w_accept;
   logic               w_s_full;
   logic               w_p_full;
   logic               w_store_str;
   logic               w_store_pat;
   logic               w_overflow;
   logic [S_CNT_W-1:0] w_s_cnt_upd;
   logic [P_CNT_W-1:0] w_p_cnt_upd;
   logic               w_job_first;
   logic               w_last_acc;
   logic               w_last_bad;
   logic               w_last_good;

   assign w_accept    = in_valid & r_in_ready & (r_state == ST_COLLECT);
   assign w_s_full    = (r_s_cnt == S_FULL);
   assign w_p_full    = (r_p_cnt == P_FULL);
   assign w_store_str = w_accept & ~in_sel & ~w_s_full;
   assign w_store_pat = w_accept &  in_sel & ~w_p_full;
   assign w_overflow  = w_accept & (in_sel ? w_p_full : w_s_full);

   // Counts as they stand after this cycle's byte (saturating on overflow)
   assign w_s_cnt_upd = r_s_cnt + (w_store_str ? S_ONE : '0);
   assign w_p_cnt_upd = r_p_cnt + (w_store_pat ? P_ONE : '0);

   // Both counters are zero only before the first byte of a job, so this
   // identifies the byte that clears a stale err.
   assign w_job_first = (r_s_cnt == '0) && (r_p_cnt == '0);

   assign w_last_acc  = w_accept & in_last;
   assign w_last_bad  = w_last_acc & ((w_s_cnt_upd == '0) | (w_p_cnt_upd == '0));
   assign w_last_good = w_last_acc & ~w_last_bad;

   // ------------------------------------------------------------------------
   // Burst-side decode
   // ------------------------------------------------------------------------
   logic               w_str_end;
   logic               w_pat_end;
   logic [IDX_W-1:0]   w_idx_inc;
   logic [S_IDX_W-1:0] w_s_rd;
   logic [P_IDX_W-1:0] w_p_rd;
   logic [BYTE-1:0]    w_first_str;

   assign w_str_end = (r_idx == IDX_W'(r_s_cnt - S_ONE));
   assign w_pat_end = (r_idx == IDX_W'(r_p_cnt - P_ONE));
   assign w_idx_inc = r_idx + IDX_ONE;
   assign w_s_rd    = S_IDX_W'(w_idx_inc);
   assign w_p_rd    = P_IDX_W'(w_idx_inc);

   // The first beat is registered on the same edge that accepts in_last. If
   // that byte is itself the job's only string byte it is being written into
   // str_buf[0] on that edge, so forward it instead of reading stale storage.
   assign w_first_str = (w_store_str && (r_s_cnt == '0)) ? in_data : r_str_buf[0];

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_COLLECT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_COLLECT:    if (w_last_good) w_next_state = ST_SEND_STR;
         ST_SEND_STR:   if (w_str_end)   w_next_state = ST_SEND_PAT;
         ST_SEND_PAT:   if (w_pat_end)   w_next_state = ST_WAIT_VALID;
         ST_WAIT_VALID: if (mem_valid)   w_next_state = ST_COLLECT;
         default:                        w_next_state = ST_COLLECT;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: output logic. Produces the values the output registers take at the
   // next edge, so each beat is presented in the cycle the state implies and
   // the string-to-pattern handoff has no idle cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      w_nxt_ready = 1'b0;
      w_nxt_write = 1'b0;
      w_nxt_sel   = 1'b0;
      w_nxt_data  = '0;
      w_nxt_done  = 1'b0;
      w_nxt_idx   = r_idx;
      case (r_state)
         ST_COLLECT: begin
            if (w_last_good) begin
               w_nxt_write = 1'b1;
               w_nxt_data  = w_first_str;
               w_nxt_idx   = '0;
            end else begin
               w_nxt_ready = 1'b1;
            end
         end
         ST_SEND_STR: begin
            w_nxt_write = 1'b1;
            if (w_str_end) begin
               w_nxt_sel  = 1'b1;
               w_nxt_data = r_pat_buf[0];
               w_nxt_idx  = '0;
            end else begin
               w_nxt_data = r_str_buf[w_s_rd];
               w_nxt_idx  = w_idx_inc;
            end
         end
         ST_SEND_PAT: begin
            if (w_pat_end) begin
               w_nxt_idx = '0;
            end else begin
               w_nxt_write = 1'b1;
               w_nxt_sel   = 1'b1;
               w_nxt_data  = r_pat_buf[w_p_rd];
               w_nxt_idx   = w_idx_inc;
            end
         end
         ST_WAIT_VALID: begin
            if (mem_valid) begin
               w_nxt_done  = 1'b1;
               w_nxt_ready = 1'b1;
            end
         end
         default: begin
            w_nxt_idx = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output and burst-index registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_ready <= 1'b0;
         r_write    <= 1'b0;
         r_w_sel    <= 1'b0;
         r_w_data   <= '0;
         r_done     <= 1'b0;
         r_idx      <= '0;
      end else begin
         r_in_ready <= w_nxt_ready;
         r_write    <= w_nxt_write;
         r_w_sel    <= w_nxt_sel;
         r_w_data   <= w_nxt_data;
         r_done     <= w_nxt_done;
         r_idx      <= w_nxt_idx;
      end
   end

   // ------------------------------------------------------------------------
   // Job counters: they alone define the payload; buffers are never cleared.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s_cnt <= '0;
         r_p_cnt <= '0;
      end else if (r_state == ST_COLLECT) begin
         if (w_last_bad) begin
            r_s_cnt <= '0;
            r_p_cnt <= '0;
         end else begin
            r_s_cnt <= w_s_cnt_upd;
            r_p_cnt <= w_p_cnt_upd;
         end
      end else if ((r_state == ST_WAIT_VALID) && mem_valid) begin
         r_s_cnt <= '0;
         r_p_cnt <= '0;
      end
   end

   // Sticky error: set by overflow or an empty class at in_last, dropped by
   // the first accepted byte of the following job.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= (r_err & ~w_job_first) | w_overflow | w_last_bad;
      end
   end

   // ------------------------------------------------------------------------
   // Job buffers (no reset; contents are only read below the counters)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_store_str) begin
         r_str_buf[r_s_cnt[S_IDX_W-1:0]] <= in_data;
      end
      if (w_store_pat) begin
         r_pat_buf[r_p_cnt[P_IDX_W-1:0]] <= in_data;
      end
   end

   assign in_ready = r_in_ready;
   assign write    = r_write;
   assign w_sel    = r_w_sel;
   assign w_data   = r_w_data;
   assign done     = r_done;
   assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_smem_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_smem_writer
//  Purpose  : Directed self-checking bench for smem_writer. A small stand-in
//             for shared_memory raises valid one cycle after write falls; a
//             negedge monitor records every burst beat for comparison.
//  Revision : 1.0  initial release
// ============================================================================
module tb_smem_writer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_sel;
   logic       in_last;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] w_data;
   logic       write;
   logic       w_sel;
   logic       mem_valid;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   smem_writer #(
      .BYTE        (8),
      .MAX_STRING  (32),
      .MAX_PATTERN (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .w_data    (w_data),
      .write     (write),
      .w_sel     (w_sel),
      .mem_valid (mem_valid),
      .done      (done),
      .err       (err)
   );

   // shared_memory stand-in: valid one cycle after the write fall
   logic prev_write  = 1'b0;
   logic model_valid = 1'b0;
   logic force_valid = 1'b0;
   assign mem_valid = model_valid | force_valid;

   always @(posedge clk) begin
      if (reset) begin
         prev_write  <= 1'b0;
         model_valid <= 1'b0;
      end else begin
         prev_write  <= write;
         model_valid <= prev_write & ~write;
      end
   end

   // Beat monitor
   logic [8:0] cap_mem [0:255];
   int   cap_n    = 0;
   int   n_bursts = 0;
   int   done_cnt = 0;
   int   idle_bad = 0;
   logic mon_prev = 1'b0;

   always @(negedge clk) begin
      if (write) begin
         cap_mem[cap_n[7:0]] <= {w_sel, w_data};
         cap_n <= cap_n + 1;
      end
      if (!write && (w_sel || (w_data != 8'h00))) idle_bad <= idle_bad + 1;
      if (write && !mon_prev) n_bursts <= n_bursts + 1;
      if (done) done_cnt <= done_cnt + 1;
      mon_prev <= write;
   end

   // Present one byte and hold it until accepted. With keep=1, in_valid stays
   // high afterwards so the caller can stream the next byte without a gap.
   task automatic send_byte(input logic sel, input logic [7:0] data,
                            input logic last, input logic keep);
      int guard;
      in_sel   = sel;
      in_data  = data;
      in_last  = last;
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
      end
      @(posedge clk); #1;
      if (!keep) begin
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   // Cycles from just after in_last acceptance until done is seen
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!done && cycles < 200) begin
         @(posedge clk); #1;
         cycles++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, cycles);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, write, w_sel, w_data, done, err} !== 13'h0) begin
         errors++;
         $display("FAIL reset_values: got rdy=%0b wr=%0b sel=%0b data=%h done=%0b err=%0b, required all 0",
                  in_ready, write, w_sel, w_data, done, err);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %0b, required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      logic [8:0] exp_b [5] = '{9'h061, 9'h062, 9'h063, 9'h161, 9'h162};
      int c0, b0, d0, cyc;
      c0 = cap_n; b0 = n_bursts; d0 = done_cnt;
      send_byte(1'b0, 8'h61, 1'b0, 1'b0);
      send_byte(1'b0, 8'h62, 1'b0, 1'b0);
      send_byte(1'b0, 8'h63, 1'b0, 1'b0);
      send_byte(1'b1, 8'h61, 1'b0, 1'b0);
      send_byte(1'b1, 8'h62, 1'b1, 1'b0);
      checks++;
      if ({write, w_sel, w_data, in_ready} !== {1'b1, 1'b0, 8'h61, 1'b0}) begin
         errors++;
         $display("FAIL basic_first_beat: got wr=%0b sel=%0b data=%h rdy=%0b, required 1 0 61 0",
                  write, w_sel, w_data, in_ready);
      end
      wait_done(cyc);
      checks++;
      if (cyc !== 7) begin
         errors++;
         $display("FAIL basic_done_latency: got %0d cycles, required 7", cyc);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_ready_at_done: got %0b, required 1", in_ready);
      end
      @(negedge clk); #1;
      checks++;
      if ((cap_n - c0) !== 5 || (n_bursts - b0) !== 1 || (done_cnt - d0) !== 1) begin
         errors++;
         $display("FAIL basic_counts: got beats=%0d bursts=%0d dones=%0d, required 5 1 1",
                  cap_n - c0, n_bursts - b0, done_cnt - d0);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cap_mem[8'(c0 + i)] !== exp_b[i]) begin
            errors++;
            $display("FAIL basic_beat%0d: got %h, required %h", i, cap_mem[8'(c0 + i)], exp_b[i]);
         end
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL basic_err: got %0b, required 0", err);
      end
   endtask

   task automatic test_interleave();
      logic [8:0] exp_b [6] = '{9'h010, 9'h011, 9'h1A0, 9'h1A1, 9'h077, 9'h155};
      int c0, b0, cyc;
      c0 = cap_n; b0 = n_bursts;
      send_byte(1'b1, 8'hA0, 1'b0, 1'b0);
      send_byte(1'b0, 8'h10, 1'b0, 1'b0);
      send_byte(1'b1, 8'hA1, 1'b0, 1'b0);
      send_byte(1'b0, 8'h11, 1'b1, 1'b0);
      wait_done(cyc);
      checks++;
      if (cyc !== 6) begin
         errors++;
         $display("FAIL interleave_latency: got %0d cycles, required 6", cyc);
      end
      // Single string byte arriving last: first beat must be that byte, not
      // the stale 0x10 left in the buffer.
      send_byte(1'b1, 8'h55, 1'b0, 1'b0);
      send_byte(1'b0, 8'h77, 1'b1, 1'b0);
      checks++;
      if ({write, w_sel, w_data} !== {1'b1, 1'b0, 8'h77}) begin
         errors++;
         $display("FAIL bypass_first_beat: got wr=%0b sel=%0b data=%h, required 1 0 77", write, w_sel, w_data);
      end
      wait_done(cyc);
      @(negedge clk); #1;
      checks++;
      if ((cap_n - c0) !== 6 || (n_bursts - b0) !== 2) begin
         errors++;
         $display("FAIL interleave_counts: got beats=%0d bursts=%0d, required 6 2", cap_n - c0, n_bursts - b0);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (cap_mem[8'(c0 + i)] !== exp_b[i]) begin
            errors++;
            $display("FAIL interleave_beat%0d: got %h, required %h", i, cap_mem[8'(c0 + i)], exp_b[i]);
         end
      end
   endtask

   task automatic test_overflow();
      int c0, b0, cyc;
      logic [8:0] expv;
      c0 = cap_n; b0 = n_bursts;
      for (int i = 0; i < 32; i++) send_byte(1'b0, 8'(i + 1), 1'b0, 1'b0);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL overflow_full_no_err: got %0b, required 0", err);
      end
      send_byte(1'b0, 8'h21, 1'b0, 1'b0);
      checks++;
      if ({err, in_ready} !== 2'b11) begin
         errors++;
         $display("FAIL overflow_err: got err=%0b rdy=%0b, required 1 1", err, in_ready);
      end
      send_byte(1'b1, 8'hEE, 1'b1, 1'b0);
      wait_done(cyc);
      checks++;
      if (cyc !== 35 || err !== 1'b1) begin
         errors++;
         $display("FAIL overflow_done: got cycles=%0d err=%0b, required 35 1", cyc, err);
      end
      @(negedge clk); #1;
      checks++;
      if ((cap_n - c0) !== 33 || (n_bursts - b0) !== 1) begin
         errors++;
         $display("FAIL overflow_counts: got beats=%0d bursts=%0d, required 33 1", cap_n - c0, n_bursts - b0);
      end
      for (int i = 0; i < 33; i++) begin
         expv = (i < 32) ? {1'b0, 8'(i + 1)} : 9'h1EE;
         checks++;
         if (cap_mem[8'(c0 + i)] !== expv) begin
            errors++;
            $display("FAIL overflow_beat%0d: got %h, required %h", i, cap_mem[8'(c0 + i)], expv);
         end
      end
   endtask

   task automatic test_no_pattern();
      int c0, b0, d0, cyc;
      c0 = cap_n; b0 = n_bursts; d0 = done_cnt;
      send_byte(1'b0, 8'h91, 1'b0, 1'b0);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL nopat_err_cleared: got %0b, required 0", err);
      end
      send_byte(1'b0, 8'h92, 1'b0, 1'b0);
      send_byte(1'b0, 8'h93, 1'b0, 1'b0);
      send_byte(1'b0, 8'h94, 1'b1, 1'b0);
      checks++;
      if ({err, in_ready, write} !== 3'b110) begin
         errors++;
         $display("FAIL nopat_discard: got err=%0b rdy=%0b wr=%0b, required 1 1 0", err, in_ready, write);
      end
      // A stray memory valid while collecting must not produce done.
      force_valid = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      force_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if ((n_bursts - b0) !== 0 || (done_cnt - d0) !== 0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL nopat_idle: got bursts=%0d dones=%0d rdy=%0b, required 0 0 1",
                  n_bursts - b0, done_cnt - d0, in_ready);
      end
      send_byte(1'b0, 8'h31, 1'b0, 1'b0);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL nopat_next_err: got %0b, required 0", err);
      end
      send_byte(1'b1, 8'h41, 1'b1, 1'b0);
      wait_done(cyc);
      @(negedge clk); #1;
      checks++;
      if ((cap_n - c0) !== 2 || cap_mem[8'(c0)] !== 9'h031 || cap_mem[8'(c0 + 1)] !== 9'h141) begin
         errors++;
         $display("FAIL nopat_next_job: got beats=%0d b0=%h b1=%h, required 2 031 141",
                  cap_n - c0, cap_mem[8'(c0)], cap_mem[8'(c0 + 1)]);
      end
   endtask

   task automatic test_reset_mid_burst();
      int c0, cyc;
      c0 = cap_n;
      send_byte(1'b0, 8'h21, 1'b0, 1'b0);
      send_byte(1'b0, 8'h22, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_byte(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      send_byte(1'b1, 8'h48, 1'b1, 1'b0);
      checks++;
      if ({write, err} !== 2'b11) begin
         errors++;
         $display("FAIL midrst_burst_start: got wr=%0b err=%0b, required 1 1", write, err);
      end
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, write, w_sel, w_data, done, err} !== 13'h0) begin
         errors++;
         $display("FAIL midrst_values: got rdy=%0b wr=%0b sel=%0b data=%h done=%0b err=%0b, required all 0",
                  in_ready, write, w_sel, w_data, done, err);
      end
      checks++;
      if ((cap_n - c0) !== 3 || cap_mem[8'(c0 + 2)] !== 9'h140) begin
         errors++;
         $display("FAIL midrst_beats: got beats=%0d beat2=%h, required 3 140", cap_n - c0, cap_mem[8'(c0 + 2)]);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      c0 = cap_n;
      send_byte(1'b0, 8'hB0, 1'b0, 1'b0);
      send_byte(1'b0, 8'hB1, 1'b0, 1'b0);
      send_byte(1'b1, 8'hC0, 1'b1, 1'b0);
      wait_done(cyc);
      @(negedge clk); #1;
      checks++;
      if (cyc !== 5 || (cap_n - c0) !== 3 || cap_mem[8'(c0)] !== 9'h0B0 ||
          cap_mem[8'(c0 + 1)] !== 9'h0B1 || cap_mem[8'(c0 + 2)] !== 9'h1C0 || err !== 1'b0) begin
         errors++;
         $display("FAIL midrst_next_job: got cyc=%0d beats=%0d %h %h %h err=%0b, required 5 3 0b0 0b1 1c0 0",
                  cyc, cap_n - c0, cap_mem[8'(c0)], cap_mem[8'(c0 + 1)], cap_mem[8'(c0 + 2)], err);
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp_b [5] = '{9'h001, 9'h002, 9'h103, 9'h004, 9'h105};
      int c0, b0, d0, cyc, early;
      c0 = cap_n; b0 = n_bursts; d0 = done_cnt;
      send_byte(1'b0, 8'h01, 1'b0, 1'b1);
      send_byte(1'b0, 8'h02, 1'b0, 1'b1);
      send_byte(1'b1, 8'h03, 1'b1, 1'b1);
      // Next job's first byte offered immediately, in_valid never drops.
      in_sel = 1'b0; in_data = 8'h04; in_last = 1'b0;
      cyc = 0; early = 0;
      while (!done && cyc < 200) begin
         if (in_ready) early++;
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (cyc !== 5 || early !== 0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap: got cyc=%0d early_ready=%0d rdy_at_done=%0b, required 5 0 1", cyc, early, in_ready);
      end
      @(posedge clk); #1;
      send_byte(1'b1, 8'h05, 1'b1, 1'b0);
      checks++;
      if ({write, w_data} !== {1'b1, 8'h04} || (done_cnt - d0) !== 1) begin
         errors++;
         $display("FAIL b2b_second_start: got wr=%0b data=%h dones=%0d, required 1 04 1", write, w_data, done_cnt - d0);
      end
      wait_done(cyc);
      @(negedge clk); #1;
      checks++;
      if ((cap_n - c0) !== 5 || (n_bursts - b0) !== 2) begin
         errors++;
         $display("FAIL b2b_counts: got beats=%0d bursts=%0d, required 5 2", cap_n - c0, n_bursts - b0);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cap_mem[8'(c0 + i)] !== exp_b[i]) begin
            errors++;
            $display("FAIL b2b_beat%0d: got %h, required %h", i, cap_mem[8'(c0 + i)], exp_b[i]);
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      in_data  = 8'h00;
      in_sel   = 1'b0;
      in_last  = 1'b0;
      in_valid = 1'b0;
      test_reset();
      test_basic();
      test_interleave();
      test_overflow();
      test_no_pattern();
      test_reset_mid_burst();
      test_back_to_back();
      checks++;
      if (idle_bad !== 0) begin
         errors++;
         $display("FAIL idle_outputs_zero: got %0d idle cycles with nonzero w_sel/w_data, required 0", idle_bad);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
